// File: rtl/rtg_pattern_source.sv
// LFSR-based test-vector source for fault simulation, streamed over a valid/ready handshake.
// state | meaning: IDLE = waiting for start, seed loads allowed; RUN = issuing vectors; DONE = run complete, seed loads allowed
module rtg_pattern_source #(
  parameter int                WIDTH        = 60,
  parameter int                MAX_PATTERNS = 4096,
  parameter logic [WIDTH-1:0]  SEED_DEFAULT = 60'h0000_0000_0000_001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic             pat_valid,
  input  logic             pat_ready,
  output logic [WIDTH-1:0] pat_data,
  output logic [15:0]      pat_index,
  output logic             busy,
  output logic             done,
  output logic             seed_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  localparam logic [15:0] LAST_INDEX = 16'(MAX_PATTERNS - 1);

  stateT            state;
  logic [WIDTH-1:0] lfsr;
  logic [15:0]      indexQ;
  logic             validQ;
  logic             busyQ;
  logic             doneQ;
  logic             seedZeroQ;

  logic             xfer;
  logic             lastXfer;
  logic             seedIsZero;
  logic [WIDTH-1:0] lfsrNext;
  logic [WIDTH-1:0] seedValue;

  assign xfer       = validQ & pat_ready;
  assign lastXfer   = xfer && (indexQ == LAST_INDEX);
  assign lfsrNext   = {lfsr[WIDTH-2:0], lfsr[WIDTH-1] ^ lfsr[WIDTH-2]};
  assign seedIsZero = (seed == '0);
  // a zero seed would lock the register at zero, so it is replaced
  assign seedValue  = seedIsZero ? SEED_DEFAULT : seed;

  assign pat_valid = validQ;
  assign pat_data  = lfsr;
  assign pat_index = indexQ;
  assign busy      = busyQ;
  assign done      = doneQ;
  assign seed_zero = seedZeroQ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= SEED_DEFAULT;
      indexQ    <= '0;
      validQ    <= 1'b0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
      seedZeroQ <= 1'b0;
    end else begin
      seedZeroQ <= 1'b0;
      case (state)
        IDLE: begin
          if (seed_load) begin
            lfsr      <= seedValue;
            seedZeroQ <= seedIsZero;
          end
          if (start) begin
            state  <= RUN;
            indexQ <= '0;
            validQ <= 1'b1;
            busyQ  <= 1'b1;
          end
        end
        RUN: begin
          if (xfer) begin
            lfsr <= lfsrNext;
            if (!lastXfer) indexQ <= indexQ + 16'd1;
          end
          // abort wins over the terminal-count move
          if (stop) begin
            state  <= IDLE;
            validQ <= 1'b0;
            busyQ  <= 1'b0;
          end else if (lastXfer) begin
            state  <= DONE;
            validQ <= 1'b0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b1;
          end
        end
        DONE: begin
          if (seed_load) begin
            lfsr      <= seedValue;
            seedZeroQ <= seedIsZero;
          end
          if (start || stop) begin
            state <= IDLE;
            doneQ <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          validQ <= 1'b0;
          busyQ  <= 1'b0;
          doneQ  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rtg_pattern_source.md
RTG_PATTERN_SOURCE -- requirements
Module: rtg_pattern_source

Interface
- REQ-001: Parameter WIDTH, default 60: test-vector width; matches the primary-input count of the circuit under test.
- REQ-002: Parameter MAX_PATTERNS, default 4096: number of vectors issued per run; legal range 1..65535.
- REQ-003: Parameter SEED_DEFAULT, default 60'h0000_0000_0000_001: LFSR value after reset, and the substitute value when a zero seed is loaded.
- REQ-004: clk, input, 1: single clock; all state changes on the rising edge.
- REQ-005: rst_n, input, 1: reset is synchronous and active-low.
- REQ-006: start, input, 1: one-cycle request to begin a run.
- REQ-007: stop, input, 1: abort request for the current run.
- REQ-008: seed_load, input, 1: load seed into the LFSR.
- REQ-009: seed, input, WIDTH: seed value.
- REQ-010: pat_valid, output, 1: pat_data holds a vector ready to transfer.
- REQ-011: pat_ready, input, 1: the downstream fault-simulation consumer accepts the vector.
- REQ-012: pat_data, output, WIDTH: current test vector.
- REQ-013: pat_index, output, 16: zero-based ordinal of the vector on pat_data.
- REQ-014: busy, output, 1: high while in state RUN.
- REQ-015: done, output, 1: high while in state DONE.
- REQ-016: seed_zero, output, 1: one-cycle pulse when seed_load is accepted with seed equal to 0.

Function
- REQ-017: The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
- REQ-018: The LFSR SHALL be a Fibonacci register lfsr[WIDTH-1:0] with next value {lfsr[WIDTH-2:0], lfsr[59]^lfsr[58]}, i.e. polynomial x^60+x^59+1 at WIDTH=60.
- REQ-019: pat_data SHALL equal lfsr combinationally.
- REQ-020: A transfer SHALL occur on any cycle where pat_valid and pat_ready are both 1.
- REQ-021: IDLE->RUN on start; on entry, pat_index SHALL be 0 and the LFSR SHALL keep its current value.
- REQ-022: In RUN, pat_valid SHALL be 1.
- REQ-023: In RUN, on each transfer the LFSR SHALL advance one step and pat_index SHALL increment by 1.
- REQ-024: The transfer with pat_index == MAX_PATTERNS-1 SHALL move the FSM to DONE; the LFSR still advances, and pat_index holds.
- REQ-025: While pat_valid=1 and pat_ready=0, pat_data and pat_index SHALL remain stable.
- REQ-026: In IDLE and DONE, pat_valid SHALL be 0.
- REQ-027: stop in RUN SHALL move the FSM to IDLE next cycle; a transfer in that same cycle still completes, including the LFSR step.
- REQ-028: stop has priority over the terminal-count move to DONE.
- REQ-029: DONE->IDLE on start or stop; start in DONE does not begin a new run until start is asserted again from IDLE.
- REQ-030: seed_load SHALL be accepted only in IDLE or DONE; it is ignored in RUN.
- REQ-031: An accepted seed_load SHALL load seed into the LFSR, or SEED_DEFAULT when seed==0, in which case seed_zero pulses for one cycle.
- REQ-032: seed_load and start in the same IDLE cycle: the seed SHALL be loaded and the run SHALL begin, with the first vector equal to the loaded seed.
- REQ-033: The LFSR SHALL never hold all-zeros.

Reset
- REQ-034: When rst_n=0 at a clock edge, the block SHALL enter IDLE with lfsr=SEED_DEFAULT, pat_index=0, and pat_valid, busy, done, seed_zero all 0.
- REQ-035: Reset asserted mid-run SHALL abandon the run with no further transfers.
- REQ-036: Reset SHALL override start, stop and seed_load in the same cycle.

Verification
- REQ-037: Reset, start, pat_ready held 1 -> vectors 0x1, 0x2, 0x4, ... on consecutive cycles; pat_index 0,1,2,...
- REQ-038: MAX_PATTERNS=4, ready held 1 -> exactly 4 transfers, then done=1 and pat_valid=0; a fifth vector is never offered.
- REQ-039: seed_load with seed=0 in IDLE -> seed_zero pulses once; lfsr=SEED_DEFAULT.
- REQ-040: pat_ready toggled pseudo-randomly -> the transferred sequence is identical to the ready-always-1 sequence, and pat_data stays stable under stall.
- REQ-041: stop asserted in the same cycle as the 3rd transfer -> 3 transfers total, IDLE next cycle, and the LFSR advanced exactly 3 steps.
- REQ-042: rst_n=0 at pat_index=7 -> next cycle IDLE, pat_valid=0, pat_index=0, lfsr=SEED_DEFAULT.
